// File: rtl/serial_rx_port.sv
// serial_rx_port: bus-attached 8N1 UART receiver with a small receive FIFO.
// Reads of the data word pop the FIFO; an empty read returns all ones (EOF).
module serial_rx_port #(
    parameter int unsigned BASE         = 32,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DEPTH        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        rw,
    input  logic [31:0] addr,
    inout  wire  [31:0] data,
    input  logic        rxd,
    output logic        rx_avail,
    output logic        overrun
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] HalfLast = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BitLast  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CntOne   = CW'(1);
    localparam logic [AW:0]   PtrOne   = (AW + 1)'(1);
    localparam logic [31:0]   AddrData = 32'(BASE);
    localparam logic [31:0]   AddrStat = 32'(BASE + 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWait} state_e;

    state_e          state_q, state_d;
    logic            meta_q, meta_d;
    logic            rs_q, rs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic [AW:0]     wptr_q, wptr_d;
    logic [AW:0]     rptr_q, rptr_d;
    logic            framing_q, framing_d;
    logic            overrun_q, overrun_d;

    logic            tick_half, tick_bit;
    logic            cnt_run, cnt_clr, bit_take, stop_good, stop_bad;
    logic            full, empty, hit, pop, push, drop, clr;
    logic [31:0]     rdata;

    assign tick_half = (cnt_q == HalfLast);
    assign tick_bit  = (cnt_q == BitLast);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: start-bit qualification, eight data bits, stop bit, break wait.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!rs_q) state_d = StStart;
            StStart: if (tick_half) state_d = rs_q ? StIdle : StData;
            StData:  if (tick_bit && bit_idx_q == 3'd7) state_d = StStop;
            StStop:  if (tick_bit) state_d = rs_q ? StIdle : StWait;
            StWait:  if (rs_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: bit-timer control and sample strobes.
    always_comb begin
        cnt_run   = 1'b0;
        cnt_clr   = 1'b0;
        bit_take  = 1'b0;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        unique case (state_q)
            StStart: begin
                cnt_run = 1'b1;
                cnt_clr = tick_half;
            end
            StData: begin
                cnt_run  = 1'b1;
                cnt_clr  = tick_bit;
                bit_take = tick_bit;
            end
            StStop: begin
                cnt_run   = 1'b1;
                cnt_clr   = tick_bit;
                stop_good = tick_bit && rs_q;
                stop_bad  = tick_bit && !rs_q;
            end
            default: ;
        endcase
    end

    // Datapath next state: synchronizer, bit timer, shifter, FIFO and sticky flags.
    always_comb begin
        meta_d    = rxd;
        rs_d      = meta_q;
        cnt_d     = (!cnt_run || cnt_clr) ? '0 : cnt_q + CntOne;
        bit_idx_d = (state_q != StData) ? 3'd0 : (bit_take ? bit_idx_q + 3'd1 : bit_idx_q);
        shift_d   = bit_take ? {rs_q, shift_q[7:1]} : shift_q;

        full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        empty = (wptr_q == rptr_q);
        hit   = enable && (addr >= AddrData) && (addr <= AddrStat);
        pop   = enable && !rw && (addr == AddrData) && !empty;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
        push  = stop_good && (!full || pop);
        drop  = stop_good && full && !pop;
        clr   = enable && rw && (addr == AddrStat);

        mem_d = mem_q;
        if (push) mem_d[wptr_q[AW-1:0]] = shift_q;
        wptr_d = push ? wptr_q + PtrOne : wptr_q;
        rptr_d = pop ? rptr_q + PtrOne : rptr_q;

        // Set beats clear when both land in the same cycle.
        framing_d = stop_bad ? 1'b1 : (clr ? 1'b0 : framing_q);
        overrun_d = drop ? 1'b1 : (clr ? 1'b0 : overrun_q);
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q    <= 1'b1;
            rs_q      <= 1'b1;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 8'd0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            framing_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            meta_q    <= meta_d;
            rs_q      <= rs_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            mem_q     <= mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            framing_q <= framing_d;
            overrun_q <= overrun_d;
        end
    end

    // Read mux: head byte or EOF at the data word, status bits at the status word.
    always_comb begin
        if (addr == AddrData) begin
            rdata = empty ? 32'hFFFF_FFFF : {24'd0, mem_q[rptr_q[AW-1:0]]};
        end else begin
            rdata = {28'd0, framing_q, overrun_q, full, !empty};
        end
    end

    assign data     = (hit && !rw) ? rdata : 'z;
    assign rx_avail = !empty;
    assign overrun  = overrun_q;

endmodule
